// File: rtl/ov7670_config_seq_pkg.sv
// Shared definitions for the OV7670 configuration sequencer: entry layout,
// pseudo-entry markers, FSM state encoding and the camera's SCCB address.
package ov7670_config_seq_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int IDX_W   = 8;
  localparam int CNT_W   = 32;

  // Address 0xFF marks a pseudo-entry; it never reaches the camera.
  localparam logic [ADDR_W-1:0]  DELAY_ADDR       = 8'hFF;
  localparam logic [ENTRY_W-1:0] END_ENTRY        = 16'hFFFF;
  // 8-bit write address of the OV7670, consumed by the SCCB master.
  localparam logic [7:0]         SCCB_CAMERA_ADDR = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_DONE
  } state_e;

  // Counter preload for an N-millisecond delay. N = 0 becomes a single
  // pass-through cycle instead of wrapping to 0xFFFF_FFFF.
  function automatic logic [CNT_W-1:0] delay_load(input logic [DATA_W-1:0] n,
                                                  input logic [CNT_W-1:0]  ticks);
    if (n == '0) begin
      return '0;
    end
    return (CNT_W'(n) * ticks) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// Register/value table for the OV7670: {addr, data} per entry, one cycle
// of read latency. 0xFFxx entries are delays, 0xFFFF ends the table.
module ov7670_config_rom
  import ov7670_config_seq_pkg::*;
(
  input  logic               clk,
  input  logic [IDX_W-1:0]   addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [ENTRY_W-1:0] rom_entry;
  logic [ENTRY_W-1:0] data_q;

  // Table contents; anything past the end marker also reads as the marker.
  always_comb begin
    rom_entry = END_ENTRY;
    case (addr_i)
      8'd0:    rom_entry = 16'h1280; // COM7: soft reset
      8'd1:    rom_entry = 16'hFF0A; // wait 10 ms for the reset to settle
      8'd2:    rom_entry = 16'h1204; // COM7: RGB output
      8'd3:    rom_entry = 16'h40D0; // COM15: RGB565, full range
      8'd4:    rom_entry = 16'h8C00; // RGB444: disabled
      8'd5:    rom_entry = 16'h3A04; // TSLB: UV ordering
      8'd6:    rom_entry = 16'hFF00; // zero-length delay (pass-through)
      8'd7:    rom_entry = 16'h1100; // CLKRC: no prescale
      8'd8:    rom_entry = 16'h0C00; // COM3: no scaling
      8'd9:    rom_entry = 16'h3E00; // COM14: normal PCLK
      8'd10:   rom_entry = 16'h4FB3; // MTX1
      8'd11:   rom_entry = 16'h50B3; // MTX2
      8'd12:   rom_entry = 16'h5100; // MTX3
      8'd13:   rom_entry = 16'h523D; // MTX4
      8'd14:   rom_entry = 16'h53A7; // MTX5
      8'd15:   rom_entry = 16'h54E4; // MTX6
      8'd16:   rom_entry = 16'h589E; // MTXS
      default: rom_entry = END_ENTRY;
    endcase
  end

  // Registered read so the table maps onto block ROM.
  always_ff @(posedge clk) begin
    data_q <= rom_entry;
  end

  assign data_o = data_q;

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 register table and issues one SCCB write per entry,
// honouring delay and end-of-table pseudo-entries.
module ov7670_config_seq
  import ov7670_config_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 25000000,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned ACCEPT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [ADDR_W-1:0] sccb_address,
  output logic [DATA_W-1:0] sccb_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  entry_idx
);

  localparam logic [CNT_W-1:0] TICKS_PER_MS = CNT_W'(CLK_FREQ / 1000);
  // The start-pulse cycle counts as the first waited cycle, so the
  // sequencer gives up exactly ACCEPT_TIMEOUT cycles after the pulse.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACCEPT_TIMEOUT) - CNT_W'(2);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                error_q, error_d;
  logic                auto_q, auto_d;
  logic                start_d;
  logic [ENTRY_W-1:0]  rom_data;

  ov7670_config_rom u_rom (
    .clk    (clk),
    .addr_i (idx_q),
    .data_o (rom_data)
  );

  // Next-state and output logic for the table walker.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    auto_d  = 1'b0;   // auto-launch is only considered on the first cycle
    start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start || auto_q) begin
          idx_d   = '0;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_DECODE;   // ROM output valid next cycle
      end

      ST_DECODE: begin
        if (rom_data == END_ENTRY) begin
          state_d = ST_DONE;
        end else if (rom_data[ENTRY_W-1:DATA_W] == DELAY_ADDR) begin
          cnt_d   = delay_load(rom_data[DATA_W-1:0], TICKS_PER_MS);
          state_d = ST_DELAY;
        end else begin
          addr_d  = rom_data[ENTRY_W-1:DATA_W];
          data_d  = rom_data[DATA_W-1:0];
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        // Gated by ready so a master still busy after a reset never sees a start.
        if (sccb_ready) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_BUSY: begin
        if (!sccb_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (sccb_ready) begin
          if (idx_q == '1) begin
            error_d = 1'b1;      // ran off the table without an end marker
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end
      end

      ST_DELAY: begin
        if (cnt_q == '0) begin
          if (idx_q == '1) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (cfg_start) begin
          idx_d   = '0;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      auto_q  <= auto_d;
    end
  end

  assign sccb_start   = start_d;
  assign sccb_address = addr_q;
  assign sccb_data    = data_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign entry_idx    = idx_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Self-checking bench: randomized SCCB master timing, expected write list
// derived from an independent copy of the register table.
module tb_ov7670_config_seq;

  localparam int CLK_FREQ = 10000;
  localparam int AT       = 15;
  localparam int TICKS    = CLK_FREQ / 1000;
  localparam int TBL_N    = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       sccb_ready = 1'b1;
  logic       sccb_start;
  logic [7:0] sccb_address;
  logic [7:0] sccb_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] entry_idx;

  ov7670_config_seq #(
    .CLK_FREQ       (CLK_FREQ),
    .AUTO_START     (1'b1),
    .ACCEPT_TIMEOUT (AT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .sccb_ready   (sccb_ready),
    .sccb_start   (sccb_start),
    .sccb_address (sccb_address),
    .sccb_data    (sccb_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .entry_idx    (entry_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference copy of the camera table.
  logic [15:0] ref_table [0:TBL_N-1] = '{
    16'h1280, 16'hFF0A, 16'h1204, 16'h40D0, 16'h8C00, 16'h3A04,
    16'hFF00, 16'h1100, 16'h0C00, 16'h3E00, 16'h4FB3, 16'h50B3,
    16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'hFFFF };

  logic [15:0] exp_q [$];

  // SCCB master model: drops ready the cycle after a start for a random span.
  bit stuck = 1'b0;
  int busy_left = 0;
  always @(posedge clk) begin
    if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) sccb_ready <= 1'b1;
    end else if (sccb_start && !stuck) begin
      sccb_ready <= 1'b0;
      busy_left  <= $urandom_range(12, 30);
    end
  end

  // Monitor: record writes and the first cycle each entry index is seen.
  logic [15:0] wr_q [$];
  int          wr_cyc [$];
  int          viol = 0;
  bit          prev_start = 1'b0;
  int          idx_first [0:255];
  always @(negedge clk) begin
    if (sccb_start) begin
      wr_q.push_back({sccb_address, sccb_data});
      wr_cyc.push_back(cyc);
      if (!sccb_ready || prev_start) viol++;
    end
    prev_start = sccb_start;
    if (rst_n && idx_first[entry_idx] < 0) idx_first[entry_idx] = cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    viol = 0;
    for (int i = 0; i < 256; i++) idx_first[i] = -1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    check_val({tag, "_done_reached"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_cfg(input string tag);
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check_val({tag, "_restart_idx"}, 32'(entry_idx), 32'd0);
    check_val({tag, "_restart_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_restart_done"}, 32'(done), 32'd0);
  endtask

  task automatic compare_run(input string tag);
    check_val({tag, "_write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [15:0] obs;
      obs = (i < wr_q.size()) ? wr_q[i] : 16'hDEAD;
      $display("%s write %0d: got %04h expected %04h", tag, i, obs, exp_q[i]);
      check_val($sformatf("%s_write_%0d", tag, i), 32'(obs), 32'(exp_q[i]));
    end
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_val({tag, "_error_end"}, 32'(error), 32'd0);
    check_val({tag, "_start_protocol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int n;
    int c0;
    int first_rise;

    // Expected writes: every entry before the end marker whose address is not 0xFF.
    for (int i = 0; i < TBL_N; i++) begin
      if (ref_table[i] == 16'hFFFF) break;
      if (ref_table[i][15:8] != 8'hFF) exp_q.push_back(ref_table[i]);
    end
    clear_mon();

    // Reset state.
    repeat (3) tick();
    check_val("reset_outputs",
              32'({sccb_start, sccb_address, sccb_data, busy, done, error, entry_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run 1: auto-start from reset, full table.
    wait_done("run1");
    compare_run("run1");
    if (wr_cyc.size() >= 2) begin
      check_val("delay_gap_ge_10ms", 32'((wr_cyc[1] - wr_cyc[0]) >= 10 * TICKS), 32'd1);
    end
    check_val("zero_delay_advance",
              32'(idx_first[6] >= 0 && idx_first[7] > idx_first[6] && (idx_first[7] - idx_first[6]) <= 3),
              32'd1);

    // Run 2: restart from DONE, cfg_start mid-sequence must be ignored.
    clear_mon();
    pulse_cfg("run2");
    n = 0;
    while (entry_idx != 8'd5 && n < 2000) begin
      tick();
      n++;
    end
    check_val("run2_reached_idx5", 32'(entry_idx), 32'd5);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("run2");
    compare_run("run2");

    // Run 3: master never accepts -> timeout.
    stuck = 1'b1;
    clear_mon();
    pulse_cfg("run3");
    n = 0;
    while (wr_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    check_val("run3_first_write", 32'((wr_q.size() > 0) ? wr_q[0] : 16'hDEAD), 32'h1280);
    c0 = (wr_cyc.size() > 0) ? wr_cyc[0] : 0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check_val("timeout_latency", 32'(cyc - c0), 32'(AT));
    check_val("timeout_error", 32'(error), 32'd1);
    check_val("timeout_done", 32'(done), 32'd1);

    // Run 4: restart clears error, then reset while the master is busy.
    stuck = 1'b0;
    clear_mon();
    pulse_cfg("run4");
    check_val("run4_error_cleared", 32'(error), 32'd0);
    n = 0;
    while (wr_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    check_val("run4_first_write", 32'((wr_q.size() > 0) ? wr_q[0] : 16'hDEAD), 32'h1280);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs",
              32'({sccb_start, sccb_address, sccb_data, busy, done, error, entry_idx}), 32'd0);
    repeat (2) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    n = 0;
    while (!sccb_ready && n < 100) begin
      tick();
      n++;
    end
    first_rise = cyc;
    wait_done("run4");
    compare_run("run4");
    check_val("no_start_into_busy_master",
              32'(wr_cyc.size() > 0 && wr_cyc[0] >= first_rise), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
